// File: rtl/rpc2_ctrl_fifo_gray_ptr.sv
// rpc2_ctrl_fifo_gray_ptr: one side of the async FIFO.
// It holds the gray pointer, the remote-pointer synchroniser and the registered full/empty/level flags.
module rpc2_ctrl_fifo_gray_ptr #(
    parameter int ADDR_WIDTH    = 8,
    parameter int MODE          = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int ALMOST_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [ADDR_WIDTH:0]   remote_gray_ptr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic                  flag,
    output logic                  almost_flag,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  accept
);
    localparam int AW = ADDR_WIDTH;
    localparam logic MF = (MODE != 0);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LO_T = (AW+1)'(ALMOST_THRESH);
    localparam logic [AW:0] HI_T = DEPTH - LO_T;

    logic [AW:0] bin_ptr, next_bin, next_gray, rsync, rbin, level_next;
    logic [AW:0] sync_q [SYNC_STAGES];
    logic        flag_next, almost_next;

    assign accept    = en & ~flag;
    assign addr      = bin_ptr[AW-1:0];
    assign next_bin  = bin_ptr + {{AW{1'b0}}, accept};
    assign next_gray = next_bin ^ (next_bin >> 1);
    assign rsync     = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) rbin[i] = ^(rsync >> i);
    end

    // Write side is full when the pointers differ only in their top two gray bits
    assign level_next  = !MF ? next_bin - rbin : rbin - next_bin;
    assign flag_next   = !MF ? next_gray == {~rsync[AW:AW-1], rsync[AW-2:0]} : next_gray == rsync;
    assign almost_next = !MF ? level_next >= HI_T : level_next <= LO_T;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_ptr     <= '0;
            gray_ptr    <= '0;
            level       <= '0;
            flag        <= MF;
            almost_flag <= MF;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else if (clr) begin
            bin_ptr     <= '0;
            gray_ptr    <= '0;
            level       <= '0;
            flag        <= MF;
            almost_flag <= MF;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            bin_ptr     <= next_bin;
            gray_ptr    <= next_gray;
            level       <= level_next;
            flag        <= flag_next;
            almost_flag <= almost_next;
            sync_q[0]   <= remote_gray_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
endmodule

// File: tb/tb_rpc2_ctrl_fifo_gray_ptr.sv
// tb_rpc2_ctrl_fifo_gray_ptr: write-side and read-side instances (AW=3) checked against a counter/delay-line model.
module tb_rpc2_ctrl_fifo_gray_ptr;
    logic       clk = 0, rst_n;
    logic       clr_s [2], en_s [2];
    logic [3:0] rgp [2], gray_o [2], level_o [2];
    logic [2:0] addr_o [2];
    logic       flag_o [2], alm_o [2], acc_o [2];

    always #5 clk = ~clk;

    rpc2_ctrl_fifo_gray_ptr #(.ADDR_WIDTH(3), .MODE(0), .SYNC_STAGES(2), .ALMOST_THRESH(4)) u_w (
        .clk(clk), .rst_n(rst_n), .clr(clr_s[0]), .en(en_s[0]), .remote_gray_ptr(rgp[0]),
        .addr(addr_o[0]), .gray_ptr(gray_o[0]), .flag(flag_o[0]), .almost_flag(alm_o[0]),
        .level(level_o[0]), .accept(acc_o[0]));

    rpc2_ctrl_fifo_gray_ptr #(.ADDR_WIDTH(3), .MODE(1), .SYNC_STAGES(2), .ALMOST_THRESH(4)) u_r (
        .clk(clk), .rst_n(rst_n), .clr(clr_s[1]), .en(en_s[1]), .remote_gray_ptr(rgp[1]),
        .addr(addr_o[1]), .gray_ptr(gray_o[1]), .flag(flag_o[1]), .almost_flag(alm_o[1]),
        .level(level_o[1]), .accept(acc_o[1]));

    int vectors = 0, miscompares = 0;
    // Model: lc = local ops done, rem = remote ops done, d0/d1 = remote count as seen through the sync delay
    int lc [2], rem [2], d0 [2], d1 [2], lv [2];
    bit fl [2], al [2];

    function automatic logic [3:0] b2g(int b);
        logic [3:0] v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            lc[m] = 0; rem[m] = 0; d0[m] = 0; d1[m] = 0; lv[m] = 0;
            fl[m] = (m == 1); al[m] = (m == 1);
        end
    endtask

    task automatic check_all(string ph);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.addr%0d", ph, m), 32'(addr_o[m]), lc[m] % 8);
            chk($sformatf("%s.gray%0d", ph, m), 32'(gray_o[m]), 32'(b2g(lc[m])));
            chk($sformatf("%s.level%0d", ph, m), 32'(level_o[m]), lv[m]);
            chk($sformatf("%s.flag%0d", ph, m), 32'(flag_o[m]), 32'(fl[m]));
            chk($sformatf("%s.almost%0d", ph, m), 32'(alm_o[m]), 32'(al[m]));
        end
    endtask

    task automatic step(bit e0, bit a0, bit c0, bit e1, bit a1, bit c1, string ph);
        en_s[0] = e0; clr_s[0] = c0; en_s[1] = e1; clr_s[1] = c1;
        if (a0) rem[0]++;
        if (a1) rem[1]++;
        for (int m = 0; m < 2; m++) begin
            if (clr_s[m]) rem[m] = 0;
            rgp[m] = b2g(rem[m]);
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.accept%0d", ph, m), 32'(acc_o[m]), 32'(en_s[m] && !fl[m]));
            if (clr_s[m]) begin
                lc[m] = 0; d0[m] = 0; d1[m] = 0; lv[m] = 0;
                fl[m] = (m == 1); al[m] = (m == 1);
            end else begin
                lc[m] += (en_s[m] && !fl[m]) ? 1 : 0;
                lv[m] = (m == 0) ? lc[m] - d1[m] : d1[m] - lc[m];
                fl[m] = (m == 0) ? (lv[m] == 8) : (lv[m] == 0);
                al[m] = (m == 0) ? (lv[m] >= 4) : (lv[m] <= 4);
                d1[m] = d0[m];
                d0[m] = rem[m];
            end
        end
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    initial begin
        rst_n = 0;
        for (int m = 0; m < 2; m++) begin clr_s[m] = 0; en_s[m] = 0; rgp[m] = '0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 0, "fill");
            if (i == 2) chk("fill.almost_low", 32'(alm_o[0]), 0);
            if (i == 3) chk("fill.almost_at4", 32'(alm_o[0]), 1);
            if (i == 7) begin
                chk("fill.full_gray", 32'(gray_o[0]), 32'hc);
                chk("fill.full_level", 32'(level_o[0]), 8);
                chk("fill.full_flag", 32'(flag_o[0]), 1);
            end
        end
        chk("fill.frozen_addr", 32'(addr_o[0]), 0);

        rem[1] = 3;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, "radv");
            chk("radv.empty", 32'(flag_o[1]), (i < 2) ? 1 : 0);
        end
        chk("radv.level", 32'(level_o[1]), 3);
        chk("radv.almost", 32'(alm_o[1]), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, "pop");
        chk("pop.empty", 32'(flag_o[1]), 1);
        chk("pop.level", 32'(level_o[1]), 0);

        step(0, 0, 1, 0, 0, 1, "clr_both");
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, "to7");
        step(0, 1, 0, 0, 0, 0, "sim_a");
        step(0, 0, 0, 0, 0, 0, "sim_b");
        step(1, 0, 0, 0, 0, 0, "sim_c");
        chk("sim.level", 32'(level_o[0]), 7);
        chk("sim.flag", 32'(flag_o[0]), 0);

        step(0, 0, 1, 0, 0, 0, "clr_w");
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, "to6");
        step(1, 0, 1, 0, 0, 0, "clr_en");
        chk("clr_en.gray", 32'(gray_o[0]), 0);
        chk("clr_en.level", 32'(level_o[0]), 0);
        chk("clr_en.almost", 32'(alm_o[0]), 0);

        rem[1] = 5;
        step(0, 0, 0, 0, 0, 0, "wrap_sync");
        for (int i = 0; i < 400; i++) begin
            bit e0, a0, c0, e1, a1, c1;
            e0 = $urandom_range(0, 3) != 0;
            a0 = (rem[0] < lc[0]) && ($urandom_range(0, 1) == 1);
            c0 = $urandom_range(0, 99) == 0;
            e1 = $urandom_range(0, 2) != 0;
            a1 = (rem[1] - lc[1] < 8) && ($urandom_range(0, 1) == 1);
            c1 = $urandom_range(0, 99) == 0;
            step(e0, a0, c0, e1, a1, c1, "rand");
            assert (lv[0] <= 8 && lv[1] <= 8) else begin
                miscompares++;
                $error("FAIL rand.model_level observed=%0d/%0d expected<=8", lv[0], lv[1]);
            end
        end

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, "pre_rst");
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.empty", 32'(flag_o[1]), 1);
        for (int m = 0; m < 2; m++) begin en_s[m] = 0; clr_s[m] = 0; rgp[m] = '0; end
        #2 rst_n = 1;
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1) == 1, 0, 0, 0, (rem[1] - lc[1] < 8), 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rpc2_ctrl_fifo_gray_ptr.md
Name: rpc2_ctrl_fifo_gray_ptr

Overview:
Parametrised pointer/flag block for one side of the rpc2_ctrl asynchronous FIFO. It generalises the plain gray counter with the following additions:
- selectable write-side or read-side mode
- a built-in multi-stage synchroniser for the opposite-domain gray pointer
- overflow/underflow-protected increment
- synchronous clear
- registered full/empty, almost-full/almost-empty and fill-level outputs

One instance sits in each clock domain of the FIFO. Each instance drives the RAM address and the gray pointer consumed by the opposite side.

Parameters:
- ADDR_WIDTH, 8, RAM address width. DEPTH = 2^ADDR_WIDTH. Pointer width is ADDR_WIDTH+1. Legal range is ≥2.
- MODE, 0, side select. 0 = write side (flag means full); 1 = read side (flag means empty).
- SYNC_STAGES, 2, number of flops in the remote-pointer synchroniser. Legal range is ≥2.
- ALMOST_THRESH, 4, almost-flag threshold in entries. Legal range is 1..DEPTH-1.

Ports:
- clk  in  1  local-domain clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of local pointer state
- en  in  1  increment request (write push or read pop)
- remote_gray_ptr  in  ADDR_WIDTH+1  opposite-domain gray pointer, unsynchronised
- addr  out  ADDR_WIDTH  RAM address = bin_ptr[ADDR_WIDTH-1:0]
- gray_ptr  out  ADDR_WIDTH+1  registered local gray pointer, exported to the opposite domain
- flag  out  1  registered full (MODE=0) or empty (MODE=1)
- almost_flag  out  1  registered almost-full (MODE=0) or almost-empty (MODE=1)
- level  out  ADDR_WIDTH+1  registered occupancy as seen from this side, 0..DEPTH
- accept  out  1  combinational: en & ~flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - bin_ptr, gray_ptr, all synchroniser flops and level = 0.
  - flag = MODE (write side 0, read side 1).
  - almost_flag = MODE.
- Synchroniser: SYNC_STAGES-deep flop chain on remote_gray_ptr; the last stage is rsync. rbin = gray-to-binary(rsync), combinational.
- Increment:
  - inc = en & ~flag. An en while full (write side) or empty (read side) is dropped with no state change.
  - next_bin = bin_ptr + inc, modulo 2^(ADDR_WIDTH+1).
  - next_gray = next_bin ^ (next_bin >> 1).
  - bin_ptr <= next_bin and gray_ptr <= next_gray every cycle. Exactly one gray bit changes per increment.
- Flags, registered and computed from next_gray/next_bin against rsync/rbin:
  - MODE=0: flag <= (next_gray == {~rsync[AW:AW-1], rsync[AW-2:0]}); level <= next_bin - rbin.
  - MODE=1: flag <= (next_gray == rsync); level <= rbin - next_bin.
  - almost_flag: MODE=0 → level_next ≥ DEPTH-ALMOST_THRESH; MODE=1 → level_next ≤ ALMOST_THRESH.
- Latency:
  - A local increment is reflected in addr, gray_ptr, flag and level on the same edge that accepts it.
  - A remote_gray_ptr change is reflected in flag and level SYNC_STAGES+1 cycles later.
  - Flags are pessimistic: full/empty may deassert late, but never deassert early.
- Wrap-around: the pointer MSB toggles every DEPTH increments. addr wraps DEPTH-1 → 0 with no bubble.
- clr (synchronous, priority over en):
  - bin_ptr, gray_ptr, level and synchroniser flops ← 0.
  - flag and almost_flag ← MODE values.
  - The en in the clr cycle is ignored.
  - The system guarantees both sides are cleared while the FIFO is idle.
- Simultaneous local inc and remote pointer change: both enter the same-cycle flag computation. No event is lost.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
1. Write-side fill and overflow protection. Setup: MODE=0, AW=3, remote held 0, en high 10 cycles. Expected:
   - accept high for 8 cycles; addr steps 0..7.
   - flag rises on the 8th accepting edge; gray_ptr = 4'b1100, level = 8.
   - almost_flag rises at level 4.
   - Cycles 9–10: accept = 0 and the pointer is frozen.
2. Read-side remote advance. Setup: MODE=1, AW=3, remote_gray_ptr stepped 0 → 4'b0010 (bin 3). Expected:
   - empty deasserts exactly SYNC_STAGES+1 = 3 cycles later.
   - level = 3; almost_flag stays 1 (3 ≤ 4).
   - Then 3 pops: empty = 1 after the 3rd, level = 0.
3. Wrap-around. Setup: MODE=1, remote pointer driven 5 entries ahead, pops interleaved for 2×DEPTH+3 operations. Expected:
   - gray_ptr changes exactly one bit per accept.
   - bin_ptr wraps 15 → 0; addr wraps 7 → 0.
   - level never exceeds 8.
4. Simultaneous events. Setup: MODE=0, level 7; push on the same edge the synchronised remote advances by 1. Expected: level stays 7 and flag stays 0.
5. clr versus en. Setup: MODE=0, level 6, clr and en together. Expected: next cycle bin = 0, gray = 0, level = 0, flag = 0, almost_flag = 0; the en is not counted.
6. Async reset mid-fill. Setup: rst_n pulsed low between clk edges at level 5. Expected: all outputs reach reset values before the next clk edge; MODE=1 instance shows flag = 1.
